// File: rtl/write_full.sv
// Write-side pointer and flag control for an async FIFO.
// Gray pointer is a bare flop output so it can cross into the read domain.
module write_full #(
    parameter int ADDR_WIDTH   = 3,
    parameter int AFULL_THRESH = 6
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  W_INC,
    input  logic [ADDR_WIDTH:0]   R_PTR_SYNC,
    output logic                  W_EN,
    output logic [ADDR_WIDTH-1:0] W_ADDR,
    output logic [ADDR_WIDTH:0]   W_PTR,
    output logic                  FULL,
    output logic                  ALMOST_FULL,
    output logic [ADDR_WIDTH:0]   W_LEVEL,
    output logic                  OVERFLOW
);

    localparam int PW = ADDR_WIDTH + 1;
    localparam logic [PW-1:0] THRESH = PW'(AFULL_THRESH);

    logic [PW-1:0] w_bin;
    logic [PW-1:0] w_bin_next;
    logic [PW-1:0] w_gray_next;
    logic [PW-1:0] r_bin;
    logic [PW-1:0] full_ptr;

    // Prefix XOR from the MSB down turns the Gray read pointer into binary
    always_comb begin
        r_bin = '0;
        r_bin[PW-1] = R_PTR_SYNC[PW-1];
        for (int i = PW - 2; i >= 0; i--) begin
            r_bin[i] = r_bin[i+1] ^ R_PTR_SYNC[i];
        end
    end

    assign full_ptr    = {~R_PTR_SYNC[PW-1:PW-2], R_PTR_SYNC[PW-3:0]};
    assign FULL        = (W_PTR == full_ptr);
    assign W_EN        = W_INC & ~FULL;
    assign W_ADDR      = w_bin[ADDR_WIDTH-1:0];
    assign W_LEVEL     = w_bin - r_bin;
    assign ALMOST_FULL = (W_LEVEL >= THRESH);
    assign w_bin_next  = w_bin + 1'b1;
    assign w_gray_next = w_bin_next ^ (w_bin_next >> 1);

    always_ff @(posedge CLK) begin
        if (!RST) begin
            w_bin    <= '0;
            W_PTR    <= '0;
            OVERFLOW <= 1'b0;
        end else begin
            if (W_EN) begin
                w_bin <= w_bin_next;
                W_PTR <= w_gray_next;
            end
            if (W_INC && FULL) begin
                OVERFLOW <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_write_full.sv
// Scoreboard bench for write_full: a count-based model predicts every
// cycle's outputs, and a negedge monitor compares them against the DUT.
module tb_write_full;

    localparam int AW    = 3;
    localparam int DEPTH = 1 << AW;
    localparam int PW    = AW + 1;
    localparam int TH    = 6;

    logic          CLK = 1'b0;
    logic          RST;
    logic          W_INC;
    logic [PW-1:0] R_PTR_SYNC;
    logic          W_EN;
    logic [AW-1:0] W_ADDR;
    logic [PW-1:0] W_PTR;
    logic          FULL;
    logic          ALMOST_FULL;
    logic [PW-1:0] W_LEVEL;
    logic          OVERFLOW;

    write_full #(.ADDR_WIDTH(AW), .AFULL_THRESH(TH)) dut (
        .CLK(CLK),
        .RST(RST),
        .W_INC(W_INC),
        .R_PTR_SYNC(R_PTR_SYNC),
        .W_EN(W_EN),
        .W_ADDR(W_ADDR),
        .W_PTR(W_PTR),
        .FULL(FULL),
        .ALMOST_FULL(ALMOST_FULL),
        .W_LEVEL(W_LEVEL),
        .OVERFLOW(OVERFLOW)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic          en;
        logic [AW-1:0] addr;
        logic [PW-1:0] ptr;
        logic          full;
        logic          afull;
        logic [PW-1:0] level;
        logic          ovf;
    } exp_t;

    exp_t q[$];
    int   errors = 0;
    int   checks = 0;

    // Model state: total accepted writes, total reads seen, sticky overflow
    int   wcnt  = 0;
    int   rcnt  = 0;
    bit   ovf_m = 1'b0;
    logic rst_edge;

    function automatic logic [PW-1:0] gray(input int n);
        logic [PW-1:0] b;
        b = PW'(n % (2 * DEPTH));
        return b ^ (b >> 1);
    endfunction

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t",
                     name, act, exp, $time);
        end
    endtask

    task automatic step(input bit rst, input bit inc);
        exp_t e;
        int   lvl;
        bit   full;
        @(posedge CLK);
        #1;
        RST        = rst;
        W_INC      = inc;
        R_PTR_SYNC = gray(rcnt);
        lvl        = wcnt - rcnt;
        full       = (lvl == DEPTH);
        e.en       = inc && !full;
        e.addr     = AW'(wcnt % DEPTH);
        e.ptr      = gray(wcnt);
        e.full     = full;
        e.afull    = (lvl >= TH);
        e.level    = PW'(lvl);
        e.ovf      = ovf_m;
        q.push_back(e);
        if (!rst) begin
            wcnt  = 0;
            rcnt  = 0;
            ovf_m = 1'b0;
        end else begin
            if (inc && !full) wcnt++;
            if (inc && full) ovf_m = 1'b1;
        end
    endtask

    always @(posedge CLK) rst_edge <= RST;

    // Monitor: one expected record per cycle, plus single-bit pointer steps
    initial begin
        exp_t          e;
        logic [PW-1:0] prev;
        bit            have_prev;
        have_prev = 1'b0;
        forever begin
            @(negedge CLK);
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("w_en", 32'(W_EN), 32'(e.en));
                chk("w_addr", 32'(W_ADDR), 32'(e.addr));
                chk("w_ptr", 32'(W_PTR), 32'(e.ptr));
                chk("full", 32'(FULL), 32'(e.full));
                chk("almost_full", 32'(ALMOST_FULL), 32'(e.afull));
                chk("w_level", 32'(W_LEVEL), 32'(e.level));
                chk("overflow", 32'(OVERFLOW), 32'(e.ovf));
                if (have_prev && rst_edge === 1'b1 && W_PTR !== prev) begin
                    chk("ptr_one_bit", 32'($countones(W_PTR ^ prev)), 32'd1);
                end
                prev      = W_PTR;
                have_prev = 1'b1;
            end
        end
    end

    initial begin
        RST        = 1'b0;
        W_INC      = 1'b1;
        R_PTR_SYNC = '0;
        // Reset held two edges with a write request pending
        step(0, 1);
        step(0, 1);
        // Fill to full from empty
        rcnt = 0;
        repeat (DEPTH) step(1, 1);
        // Writes attempted while full
        repeat (3) step(1, 1);
        step(1, 0);
        // One read frees a slot, then a write refills it
        rcnt = 1;
        step(1, 0);
        step(1, 1);
        step(1, 0);
        // Reader tracks close behind so writes wrap the pointer
        repeat (20) begin
            if (rcnt < wcnt - (DEPTH - 1)) rcnt = wcnt - (DEPTH - 1);
            step(1, 1);
        end
        // Reset mid-operation at binary count 5
        while (wcnt % (2 * DEPTH) != 5) begin
            if (rcnt < wcnt - (DEPTH - 1)) rcnt = wcnt - (DEPTH - 1);
            step(1, 1);
        end
        step(0, 1);
        step(1, 0);
        // Randomized traffic with occasional resets
        repeat (400) begin
            if ($urandom_range(0, 59) == 0) begin
                step(0, 1'($urandom_range(0, 1)));
            end else begin
                if ($urandom_range(0, 2) == 0)
                    rcnt += int'($urandom_range(0, wcnt - rcnt));
                step(1, $urandom_range(0, 3) != 0);
            end
        end
        @(posedge CLK);
        @(negedge CLK);
        #1;
        chk("queue_drained", 32'(q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
